// File: rtl/vigna_mdu_issue_if.sv
// vigna_mdu_issue_if: instruction, coprocessor and writeback signals of the M-extension issue block.
interface vigna_mdu_issue_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        cp_valid;
    logic        cp_ready;
    logic [2:0]  cp_func;
    logic [2:0]  cp_id;
    logic [31:0] cp_op1;
    logic [31:0] cp_op2;
    logic [31:0] cp_result;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport master (
        output instr_valid, instr, rs1_val, rs2_val, cp_ready, cp_result, wb_ready,
        input  instr_ready, cp_valid, cp_func, cp_id, cp_op1, cp_op2, wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  instr_valid, instr, rs1_val, rs2_val, cp_ready, cp_result, wb_ready,
        output instr_ready, cp_valid, cp_func, cp_id, cp_op1, cp_op2, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/vigna_mdu_issue.sv
// vigna_mdu_issue: decodes RV32M instructions, resolves divide corner cases locally
// and hands the rest to the coprocessor before writing back.
module vigna_mdu_issue (
    input logic clk,
    input logic resetn,
    vigna_mdu_issue_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WB = 2'd2} state_t;

    state_t      state, next;
    logic [2:0]  func;
    logic [2:0]  cp_id;
    logic [4:0]  rd;
    logic [31:0] op1, op2, wb_data;

    logic [2:0]  f;
    logic        is_m, accept, live, div_zero, ovf, fast;
    logic [31:0] fast_data;
    logic        unused_ok;

    assign f         = bus.instr[14:12];
    assign is_m      = bus.instr[6:0] == 7'b0110011 && bus.instr[31:25] == 7'b0000001;
    assign accept    = bus.instr_valid && bus.instr_ready && is_m;
    assign live      = accept && bus.instr[11:7] != 5'd0;
    assign div_zero  = f[2] && bus.rs2_val == 32'd0;
    assign ovf       = f[2] && !f[0] && bus.rs1_val == 32'h8000_0000 && bus.rs2_val == 32'hFFFF_FFFF;
    assign fast      = div_zero || ovf;
    // div-by-zero: quotient all ones, remainder is the dividend; overflow: quotient INT_MIN, remainder 0
    assign fast_data = div_zero ? (f[1] ? bus.rs1_val : 32'hFFFF_FFFF) : (f[1] ? 32'd0 : 32'h8000_0000);
    assign unused_ok = ^bus.instr[24:15];

    always_ff @(posedge clk)
        state <= !resetn ? IDLE : next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = live ? (fast ? WB : ISSUE) : IDLE;
            ISSUE:   next = bus.cp_ready ? WB : ISSUE;
            WB:      next = bus.wb_ready ? IDLE : WB;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            func    <= 3'd0;
            rd      <= 5'd0;
            op1     <= 32'd0;
            op2     <= 32'd0;
            wb_data <= 32'd0;
            cp_id   <= 3'd0;
        end else begin
            if (accept) begin
                func <= f;
                rd   <= bus.instr[11:7];
                op1  <= bus.rs1_val;
                op2  <= bus.rs2_val;
            end
            if (live && fast)
                wb_data <= fast_data;
            if (state == ISSUE && bus.cp_ready) begin
                wb_data <= bus.cp_result;
                cp_id   <= cp_id + 3'd1;
            end
        end
    end

    assign bus.instr_ready = resetn && state == IDLE;
    assign bus.cp_valid    = state == ISSUE;
    assign bus.cp_func     = func;
    assign bus.cp_id       = cp_id;
    assign bus.cp_op1      = op1;
    assign bus.cp_op2      = op2;
    assign bus.wb_valid    = state == WB;
    assign bus.wb_rd       = rd;
    assign bus.wb_data     = wb_data;
endmodule

// File: tb/tb_vigna_mdu_issue.sv
// tb_vigna_mdu_issue: directed self-checking bench for the M-extension issue block.
module tb_vigna_mdu_issue;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int passed = 0;
    int total = 0;
    int wb_pulses;

    vigna_mdu_issue_if bus();
    vigna_mdu_issue dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [2:0] fn, input logic [4:0] rd);
        return {7'b0000001, 5'd2, 5'd1, fn, rd, 7'b0110011};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        bus.instr_valid = 1'b1;
        bus.instr = ins;
        bus.rs1_val = a;
        bus.rs2_val = b;
        tick();
        bus.instr_valid = 1'b0;
    endtask

    task automatic fast(input string tag, input logic [2:0] fn, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        present(mk(fn, rd), a, b);
        check({tag, "_cp_valid"}, bus.cp_valid, 0);
        check({tag, "_wb_valid"}, bus.wb_valid, 1);
        check({tag, "_wb_rd"}, bus.wb_rd, rd);
        check({tag, "_wb_data"}, bus.wb_data, exp);
        tick();
        check({tag, "_idle"}, bus.instr_ready, 1);
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr = 32'd0;
        bus.rs1_val = 32'd0;
        bus.rs2_val = 32'd0;
        bus.cp_ready = 1'b0;
        bus.cp_result = 32'd0;
        bus.wb_ready = 1'b1;
        tick();
        tick();
        check("rst_instr_ready", bus.instr_ready, 0);
        check("rst_cp_valid", bus.cp_valid, 0);
        check("rst_cp_id", bus.cp_id, 0);
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_wb_data", bus.wb_data, 0);
        check("rst_cp_op1", bus.cp_op1, 0);
        resetn = 1'b1;
        #1;
        check("post_rst_ready", bus.instr_ready, 1);

        // MUL via coprocessor, result after 34 cycles
        present(mk(3'b000, 5'd5), 32'd7, 32'hFFFF_FFFD);
        bus.rs1_val = 32'hDEAD_BEEF;
        check("mul_cp_valid", bus.cp_valid, 1);
        check("mul_cp_id0", bus.cp_id, 0);
        check("mul_cp_func", bus.cp_func, 0);
        check("mul_ready_busy", bus.instr_ready, 0);
        wb_pulses = 0;
        for (int i = 0; i < 33; i++) begin
            tick();
            wb_pulses += int'(bus.wb_valid);
        end
        check("mul_cp_valid_hold", bus.cp_valid, 1);
        check("mul_op1_hold", bus.cp_op1, 32'd7);
        check("mul_op2_hold", bus.cp_op2, 32'hFFFF_FFFD);
        bus.cp_ready = 1'b1;
        bus.cp_result = 32'hFFFF_FFEB;
        tick();
        bus.cp_ready = 1'b0;
        bus.cp_result = 32'd0;
        wb_pulses += int'(bus.wb_valid);
        check("mul_cp_valid_drop", bus.cp_valid, 0);
        check("mul_wb_rd", bus.wb_rd, 5);
        check("mul_wb_data", bus.wb_data, 32'hFFFF_FFEB);
        check("mul_cp_id1", bus.cp_id, 1);
        tick();
        wb_pulses += int'(bus.wb_valid);
        check("mul_wb_once", wb_pulses, 1);
        check("mul_idle", bus.instr_ready, 1);
        check("mul_gap_cp_valid", bus.cp_valid, 0);

        fast("divu0", 3'b101, 5'd3, 32'd100, 32'd0, 32'hFFFF_FFFF);
        fast("remu0", 3'b111, 5'd3, 32'd100, 32'd0, 32'd100);
        fast("div_ovf", 3'b100, 5'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        fast("rem_ovf", 3'b110, 5'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        check("fast_cp_id", bus.cp_id, 1);

        present(mk(3'b001, 5'd0), 32'd3, 32'd4);
        check("rd0_cp_valid", bus.cp_valid, 0);
        check("rd0_wb_valid", bus.wb_valid, 0);
        check("rd0_ready", bus.instr_ready, 1);
        check("rd0_cp_id", bus.cp_id, 1);

        present({7'b0000000, 5'd2, 5'd1, 3'b000, 5'd5, 7'b0110011}, 32'd1, 32'd2);
        check("nonm_ready", bus.instr_ready, 1);
        check("nonm_cp_valid", bus.cp_valid, 0);
        check("nonm_wb_valid", bus.wb_valid, 0);

        bus.cp_ready = 1'b1;
        bus.cp_result = 32'h1234_5678;
        tick();
        bus.cp_ready = 1'b0;
        check("stray_cp_id", bus.cp_id, 1);
        check("stray_wb_valid", bus.wb_valid, 0);

        // writeback backpressure
        bus.wb_ready = 1'b0;
        present(mk(3'b101, 5'd7), 32'd9, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("hold_wb_valid", bus.wb_valid, 1);
            check("hold_wb_rd", bus.wb_rd, 7);
            check("hold_wb_data", bus.wb_data, 32'hFFFF_FFFF);
            check("hold_ready", bus.instr_ready, 0);
            tick();
        end
        bus.wb_ready = 1'b1;
        tick();
        check("hold_release", bus.instr_ready, 1);
        check("hold_release_wb", bus.wb_valid, 0);

        // reset in the middle of an issue
        present(mk(3'b000, 5'd1), 32'd2, 32'd3);
        check("abort_cp_valid_pre", bus.cp_valid, 1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        check("abort_cp_valid", bus.cp_valid, 0);
        check("abort_cp_id", bus.cp_id, 0);
        check("abort_wb_valid", bus.wb_valid, 0);
        tick();
        check("abort_wb_after", bus.wb_valid, 0);
        check("abort_ready", bus.instr_ready, 1);

        for (int i = 0; i < 9; i++) begin
            present(mk(3'b011, 5'd1), i, 32'd2);
            check("b2b_cp_valid", bus.cp_valid, 1);
            check("b2b_cp_id", bus.cp_id, i % 8);
            bus.cp_ready = 1'b1;
            bus.cp_result = 32'hA000_0000 + i;
            tick();
            bus.cp_ready = 1'b0;
            check("b2b_wb_data", bus.wb_data, 32'hA000_0000 + i);
            tick();
        end
        check("b2b_final_cp_id", bus.cp_id, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
